// File: rtl/adma_desc_submitter_if.sv
// rtl/adma_desc_submitter_if.sv - AXI4 write-channel bundle between the descriptor submitter and the DMA CSR slave
interface adma_desc_submitter_if #(
  parameter int MST_ID_W   = 5,
  parameter int S_ADDR_W   = 32,
  parameter int S_DATA_W   = 32,
  parameter int ATX_LEN_W  = 8,
  parameter int ATX_RESP_W = 2
);
  logic [MST_ID_W-1:0]   m_awid_o;
  logic [S_ADDR_W-1:0]   m_awaddr_o;
  logic [1:0]            m_awburst_o;
  logic [ATX_LEN_W-1:0]  m_awlen_o;
  logic                  m_awvalid_o;
  logic                  m_awready_i;
  logic [S_DATA_W-1:0]   m_wdata_o;
  logic                  m_wlast_o;
  logic                  m_wvalid_o;
  logic                  m_wready_i;
  logic [MST_ID_W-1:0]   m_bid_i;
  logic [ATX_RESP_W-1:0] m_bresp_i;
  logic                  m_bvalid_i;
  logic                  m_bready_o;

  modport master (
    output m_awid_o, m_awaddr_o, m_awburst_o, m_awlen_o, m_awvalid_o,
    output m_wdata_o, m_wlast_o, m_wvalid_o, m_bready_o,
    input  m_awready_i, m_wready_i, m_bid_i, m_bresp_i, m_bvalid_i
  );

  modport slave (
    input  m_awid_o, m_awaddr_o, m_awburst_o, m_awlen_o, m_awvalid_o,
    input  m_wdata_o, m_wlast_o, m_wvalid_o, m_bready_o,
    output m_awready_i, m_wready_i, m_bid_i, m_bresp_i, m_bvalid_i
  );
endinterface

// File: rtl/adma_desc_submitter.sv
// rtl/adma_desc_submitter.sv - programs one DMA descriptor over AXI4 writes and rings the channel doorbell (2D fields under ADMA_DESC_SUB_2D_EN)
module adma_desc_submitter #(
  parameter logic [31:0] DMA_BASE_ADDR   = 32'h8000_0000,
  parameter int          DMA_CHN_NUM     = 4,
  parameter int          DMA_LENGTH_W    = 16,
  parameter int          S_DATA_W        = 32,
  parameter int          S_ADDR_W        = 32,
  parameter int          SRC_ADDR_W      = 32,
  parameter int          DST_ADDR_W      = 32,
  parameter int          MST_ID_W        = 5,
  parameter int          ATX_LEN_W       = 8,
  parameter int          ATX_RESP_W      = 2,
  parameter int          REG_STRIDE      = 4,
  parameter int          DOORBELL_STRIDE = 16,
  parameter int          SUB_ID          = 0,
  localparam int         CHN_W           = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    desc_vld_i,
  output logic                    desc_rdy_o,
  input  logic [CHN_W-1:0]        desc_chn_i,
  input  logic [SRC_ADDR_W-1:0]   desc_src_addr_i,
  input  logic [DST_ADDR_W-1:0]   desc_dst_addr_i,
  input  logic [DMA_LENGTH_W-1:0] desc_xfer_xlen_i,
  input  logic [DMA_LENGTH_W-1:0] desc_xfer_ylen_i,
  input  logic [DMA_LENGTH_W-1:0] desc_src_strd_i,
  input  logic [DMA_LENGTH_W-1:0] desc_dst_strd_i,
  adma_desc_submitter_if.master   m_axi,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  input  logic                    err_clr_i
);

`ifdef ADMA_DESC_SUB_2D_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
  // ylen and strides have no register to land in without 2D support
  logic unused_2d_fields;
  assign unused_2d_fields = ^{desc_xfer_ylen_i, desc_src_strd_i, desc_dst_strd_i};
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [CHN_W-1:0]        chn_q, chn_d;
  logic [SRC_ADDR_W-1:0]   src_q, src_d;
  logic [DST_ADDR_W-1:0]   dst_q, dst_d;
  logic [DMA_LENGTH_W-1:0] xlen_q, xlen_d;
`ifdef ADMA_DESC_SUB_2D_EN
  logic [DMA_LENGTH_W-1:0] ylen_q, ylen_d;
  logic [DMA_LENGTH_W-1:0] sstrd_q, sstrd_d;
  logic [DMA_LENGTH_W-1:0] dstrd_q, dstrd_d;
`endif
  logic                    bad_chn_q, bad_chn_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic [S_ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [S_DATA_W-1:0]     wdata_q, wdata_d;
  logic                    rdy_q, rdy_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    set_err;
  logic                    load_wr;
  logic                    b_err;

  // Descriptor registers sit at 0x09+idx inside the channel window; the last write hits the doorbell page
  function automatic logic [S_ADDR_W-1:0] addr_of(input logic [CHN_W-1:0] chn, input logic [2:0] idx);
    logic [31:0] off;
    if (idx == LAST_IDX) begin
      off = 32'h1000 + 32'(chn) * 32'(DOORBELL_STRIDE);
    end else begin
      off = (32'(chn) * 32'd16 + 32'd9 + 32'(idx)) * 32'(REG_STRIDE);
    end
    return S_ADDR_W'(DMA_BASE_ADDR) + S_ADDR_W'(off);
  endfunction

  assign b_err = (m_axi.m_bresp_i != '0) || (m_axi.m_bid_i != MST_ID_W'(SUB_ID));

  // Next-state and next-output computation for the submit sequencer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chn_d     = chn_q;
    src_d     = src_q;
    dst_d     = dst_q;
    xlen_d    = xlen_q;
`ifdef ADMA_DESC_SUB_2D_EN
    ylen_d    = ylen_q;
    sstrd_d   = sstrd_q;
    dstrd_d   = dstrd_q;
`endif
    bad_chn_d = bad_chn_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    rdy_d     = rdy_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    set_err   = 1'b0;
    load_wr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (desc_vld_i && rdy_q) begin
          chn_d   = desc_chn_i;
          src_d   = desc_src_addr_i;
          dst_d   = desc_dst_addr_i;
          xlen_d  = desc_xfer_xlen_i;
`ifdef ADMA_DESC_SUB_2D_EN
          ylen_d  = desc_xfer_ylen_i;
          sstrd_d = desc_src_strd_i;
          dstrd_d = desc_dst_strd_i;
`endif
          idx_d   = 3'd0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
          // A bad channel spends one ISSUE cycle idle so done lands two cycles after acceptance
          if (32'(desc_chn_i) >= 32'(DMA_CHN_NUM)) begin
            bad_chn_d = 1'b1;
          end else begin
            bad_chn_d = 1'b0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            load_wr   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bad_chn_q) begin
          set_err = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          if (awvalid_q && m_axi.m_awready_i) awvalid_d = 1'b0;
          if (wvalid_q && m_axi.m_wready_i)   wvalid_d  = 1'b0;
          if (!awvalid_d && !wvalid_d) begin
            state_d  = S_RESP;
            bready_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (m_axi.m_bvalid_i) begin
          bready_d = 1'b0;
          // Abort on error so a half-written descriptor never gets its doorbell
          if (b_err || idx_q == LAST_IDX) begin
            set_err = b_err;
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d     = idx_q + 3'd1;
            state_d   = S_ISSUE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            load_wr   = 1'b1;
          end
        end
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_wr) begin
      awaddr_d = addr_of(chn_d, idx_d);
      case (idx_d)
        3'd0:    wdata_d = S_DATA_W'(src_d);
        3'd1:    wdata_d = S_DATA_W'(dst_d);
        3'd2:    wdata_d = S_DATA_W'(xlen_d);
`ifdef ADMA_DESC_SUB_2D_EN
        3'd3:    wdata_d = S_DATA_W'(ylen_d);
        3'd4:    wdata_d = S_DATA_W'(sstrd_d);
        3'd5:    wdata_d = S_DATA_W'(dstrd_d);
`endif
        default: wdata_d = S_DATA_W'(1);
      endcase
    end

    // Sticky error; a new error in the same cycle as a clear takes priority
    if (set_err)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  // State and registered outputs; reset drops all valids and any pending response
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      chn_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      xlen_q    <= '0;
`ifdef ADMA_DESC_SUB_2D_EN
      ylen_q    <= '0;
      sstrd_q   <= '0;
      dstrd_q   <= '0;
`endif
      bad_chn_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chn_q     <= chn_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      xlen_q    <= xlen_d;
`ifdef ADMA_DESC_SUB_2D_EN
      ylen_q    <= ylen_d;
      sstrd_q   <= sstrd_d;
      dstrd_q   <= dstrd_d;
`endif
      bad_chn_q <= bad_chn_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign desc_rdy_o        = rdy_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign m_axi.m_awid_o    = MST_ID_W'(SUB_ID);
  assign m_axi.m_awaddr_o  = awaddr_q;
  assign m_axi.m_awburst_o = 2'b01;
  assign m_axi.m_awlen_o   = '0;
  assign m_axi.m_awvalid_o = awvalid_q;
  assign m_axi.m_wdata_o   = wdata_q;
  assign m_axi.m_wlast_o   = wvalid_q;
  assign m_axi.m_wvalid_o  = wvalid_q;
  assign m_axi.m_bready_o  = bready_q;

endmodule

// File: tb/tb_adma_desc_submitter.sv
// tb/tb_adma_desc_submitter.sv - table-driven bench for adma_desc_submitter with a cycle-stepped CSR slave
module tb_adma_desc_submitter;

`ifdef ADMA_DESC_SUB_2D_EN
  localparam int NW = 7;
`else
  localparam int NW = 4;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        desc_vld_i, desc_vld2;
  logic        desc_rdy_o, desc_rdy2;
  logic [1:0]  desc_chn_i;
  logic [31:0] desc_src_addr_i, desc_dst_addr_i;
  logic [15:0] desc_xfer_xlen_i, desc_xfer_ylen_i, desc_src_strd_i, desc_dst_strd_i;
  logic        busy_o, done_o, err_o, err_clr_i;
  logic        busy2, done2, err2;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  always #5 aclk = ~aclk;

  adma_desc_submitter_if ifc ();
  adma_desc_submitter_if ifc2 ();

  adma_desc_submitter dut (
    .aclk(aclk), .areset(areset),
    .desc_vld_i(desc_vld_i), .desc_rdy_o(desc_rdy_o), .desc_chn_i(desc_chn_i),
    .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
    .desc_xfer_xlen_i(desc_xfer_xlen_i), .desc_xfer_ylen_i(desc_xfer_ylen_i),
    .desc_src_strd_i(desc_src_strd_i), .desc_dst_strd_i(desc_dst_strd_i),
    .m_axi(ifc.master),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  adma_desc_submitter #(.DMA_CHN_NUM(3)) dut2 (
    .aclk(aclk), .areset(areset),
    .desc_vld_i(desc_vld2), .desc_rdy_o(desc_rdy2), .desc_chn_i(desc_chn_i),
    .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
    .desc_xfer_xlen_i(desc_xfer_xlen_i), .desc_xfer_ylen_i(desc_xfer_ylen_i),
    .desc_src_strd_i(desc_src_strd_i), .desc_dst_strd_i(desc_dst_strd_i),
    .m_axi(ifc2.master),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .err_clr_i(err_clr_i)
  );

  typedef struct {
    logic [1:0]  chn;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] xlen;
    logic [15:0] ylen;
    logic [15:0] ss;
    logic [15:0] ds;
    int          aw_dly;
    int          w_dly;
    int          err_idx;
    int          err_kind;
    int          rst_idx;
    int          exp_nw;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [1:0] chn, input int i);
    if (i == NW - 1) return 32'h8000_1000 + 32'(chn) * 32'd16;
    return 32'h8000_0000 + (32'(chn) * 32'd16 + 32'd9 + 32'(i)) * 32'd4;
  endfunction

  function automatic logic [31:0] exp_data(input vec_t v, input int i);
    if (i == NW - 1) return 32'h1;
    case (i)
      0:       return v.src;
      1:       return v.dst;
      2:       return 32'(v.xlen);
      3:       return 32'(v.ylen);
      4:       return 32'(v.ss);
      default: return 32'(v.ds);
    endcase
  endfunction

  task automatic run_desc(input int k, input vec_t v);
    int   n_aw = 0, n_w = 0, n_b = 0, n_done = 0;
    int   aw_wait = 0, w_wait = 0, stab = 0, viol = 0;
    bit   aw_seen = 0, w_seen = 0, stop = 0;
    logic [31:0] aw_hold = '0, w_hold = '0;
    logic err_at_done = 1'b0;
    got_addr.delete();
    got_data.delete();
    @(negedge aclk);
    chk($sformatf("v%0d_rdy_idle", k), 32'(desc_rdy_o), 32'd1);
    desc_chn_i = v.chn; desc_src_addr_i = v.src; desc_dst_addr_i = v.dst;
    desc_xfer_xlen_i = v.xlen; desc_xfer_ylen_i = v.ylen;
    desc_src_strd_i = v.ss; desc_dst_strd_i = v.ds;
    desc_vld_i = 1'b1;
    for (int cyc = 0; cyc < 300 && !stop; cyc++) begin
      @(negedge aclk);
      desc_vld_i = 1'b0;
      ifc.m_awready_i = 1'b0;
      ifc.m_wready_i  = 1'b0;
      ifc.m_bvalid_i  = 1'b0;
      ifc.m_bresp_i   = 2'b00;
      ifc.m_bid_i     = 5'd0;
      if (done_o) begin
        n_done++;
        err_at_done = err_o;
        stop = 1;
      end
      if (ifc.m_awvalid_o) begin
        if (!aw_seen) begin aw_hold = ifc.m_awaddr_o; aw_seen = 1; aw_wait = 0; end
        else if (ifc.m_awaddr_o !== aw_hold) stab++;
        if (ifc.m_awburst_o !== 2'b01 || ifc.m_awlen_o !== 8'd0 || ifc.m_awid_o !== 5'd0) viol++;
        if (aw_wait >= v.aw_dly) begin
          ifc.m_awready_i = 1'b1;
          got_addr.push_back(ifc.m_awaddr_o);
          n_aw++;
          aw_seen = 0;
        end else aw_wait++;
      end
      if (ifc.m_wvalid_o) begin
        if (!w_seen) begin w_hold = ifc.m_wdata_o; w_seen = 1; w_wait = 0; end
        else if (ifc.m_wdata_o !== w_hold) stab++;
        if (ifc.m_wlast_o !== 1'b1) viol++;
        if (w_wait >= v.w_dly) begin
          ifc.m_wready_i = 1'b1;
          got_data.push_back(ifc.m_wdata_o);
          n_w++;
          w_seen = 0;
        end else w_wait++;
      end
      if (n_aw > n_b && n_w > n_b && ifc.m_bready_o) begin
        if (n_b == v.rst_idx) begin
          areset = 1'b1;
          stop = 1;
        end else begin
          ifc.m_bvalid_i = 1'b1;
          if (n_b == v.err_idx && v.err_kind == 1) ifc.m_bresp_i = 2'b10;
          if (n_b == v.err_idx && v.err_kind == 2) ifc.m_bid_i = 5'd3;
          n_b++;
        end
      end
    end
    if (!stop) chk($sformatf("v%0d_timeout", k), 32'(stop), 32'd1);
    chk($sformatf("v%0d_aw_count", k), 32'(n_aw), 32'(v.exp_nw));
    chk($sformatf("v%0d_w_count", k), 32'(n_w), 32'(v.exp_nw));
    for (int i = 0; i < v.exp_nw && i < got_addr.size() && i < got_data.size(); i++) begin
      chk($sformatf("v%0d_addr%0d", k, i), got_addr[i], exp_addr(v.chn, i));
      chk($sformatf("v%0d_data%0d", k, i), got_data[i], exp_data(v, i));
    end
    chk($sformatf("v%0d_done_pulses", k), 32'(n_done), 32'(v.exp_done));
    chk($sformatf("v%0d_stable", k), 32'(stab), 32'd0);
    chk($sformatf("v%0d_fixed_fields", k), 32'(viol), 32'd0);
    if (v.exp_done != 0) chk($sformatf("v%0d_err_at_done", k), 32'(err_at_done), 32'(v.exp_err));
  endtask

  initial begin
    logic [31:0] lit[$];
    areset = 1'b1; desc_vld_i = 1'b0; desc_vld2 = 1'b0; err_clr_i = 1'b0;
    desc_chn_i = '0; desc_src_addr_i = '0; desc_dst_addr_i = '0;
    desc_xfer_xlen_i = '0; desc_xfer_ylen_i = '0; desc_src_strd_i = '0; desc_dst_strd_i = '0;
    ifc.m_awready_i = 1'b0; ifc.m_wready_i = 1'b0; ifc.m_bvalid_i = 1'b0;
    ifc.m_bresp_i = 2'b00; ifc.m_bid_i = 5'd0;
    ifc2.m_awready_i = 1'b0; ifc2.m_wready_i = 1'b0; ifc2.m_bvalid_i = 1'b0;
    ifc2.m_bresp_i = 2'b00; ifc2.m_bid_i = 5'd0;

    //          chn    src           dst           xlen      ylen      ss        ds        awd wd eidx ek ridx exp_nw done err
    vecs[0] = '{2'd1, 32'h1000_0000, 32'h2000_0000, 16'h0040, 16'h0003, 16'h0100, 16'h0200, 0, 0, -1, 0, -1, NW, 1, 1'b0};
    vecs[1] = '{2'd0, 32'h0000_1234, 32'h0000_5678, 16'h0080, 16'h0002, 16'h0010, 16'h0020, 0, 0, -1, 0, -1, NW, 1, 1'b0};
    vecs[2] = '{2'd2, 32'hA000_0000, 32'hB000_0004, 16'hFFFF, 16'h0001, 16'h0008, 16'h0008, 3, 0, -1, 0, -1, NW, 1, 1'b0};
    vecs[3] = '{2'd3, 32'hFFFF_FFF0, 32'h0000_0000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 2, -1, 0, -1, NW, 1, 1'b0};
    vecs[4] = '{2'd1, 32'h1111_1111, 32'h2222_2222, 16'h0010, 16'h0010, 16'h0004, 16'h0004, 0, 0,  2, 1, -1,  3, 1, 1'b1};
    vecs[5] = '{2'd2, 32'h3333_3333, 32'h4444_4444, 16'h0020, 16'h0005, 16'h0006, 16'h0007, 0, 0, -1, 0,  3,  4, 0, 1'b0};
    vecs[6] = '{2'd0, 32'h5555_0000, 32'h6666_0000, 16'h0030, 16'h0009, 16'h000A, 16'h000B, 1, 1, -1, 0, -1, NW, 1, 1'b0};
    vecs[7] = '{2'd3, 32'h7777_0000, 32'h8888_0000, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 0, 0,  0, 2, -1,  1, 1, 1'b1};

    repeat (3) @(negedge aclk);
    chk("rst_rdy", 32'(desc_rdy_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_awvalid", 32'(ifc.m_awvalid_o), 32'd0);
    chk("rst_wvalid", 32'(ifc.m_wvalid_o), 32'd0);
    chk("rst_bready", 32'(ifc.m_bready_o), 32'd0);
    chk("rst_rdy2", 32'(desc_rdy2), 32'd1);
    areset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run_desc(k, vecs[k]);
`ifdef ADMA_DESC_SUB_2D_EN
      if (k == 0) begin
        lit = '{32'h8000_0064, 32'h8000_0068, 32'h8000_006C, 32'h8000_0070,
                32'h8000_0074, 32'h8000_0078, 32'h8000_1010};
        for (int i = 0; i < lit.size() && i < got_addr.size(); i++)
          chk($sformatf("plan_2d_addr%0d", i), got_addr[i], lit[i]);
      end
`else
      if (k == 1) begin
        lit = '{32'h8000_0024, 32'h8000_0028, 32'h8000_002C, 32'h8000_1000};
        for (int i = 0; i < lit.size() && i < got_addr.size(); i++)
          chk($sformatf("plan_1d_addr%0d", i), got_addr[i], lit[i]);
      end
`endif
      if (vecs[k].exp_err) begin
        @(negedge aclk);
        chk($sformatf("v%0d_err_sticky", k), 32'(err_o), 32'd1);
        err_clr_i = 1'b1;
        @(negedge aclk);
        err_clr_i = 1'b0;
        chk($sformatf("v%0d_err_cleared", k), 32'(err_o), 32'd0);
      end
      if (vecs[k].rst_idx >= 0) begin
        @(negedge aclk);
        chk($sformatf("v%0d_rst_awvalid", k), 32'(ifc.m_awvalid_o), 32'd0);
        chk($sformatf("v%0d_rst_wvalid", k), 32'(ifc.m_wvalid_o), 32'd0);
        chk($sformatf("v%0d_rst_bready", k), 32'(ifc.m_bready_o), 32'd0);
        chk($sformatf("v%0d_rst_rdy", k), 32'(desc_rdy_o), 32'd1);
        chk($sformatf("v%0d_rst_busy", k), 32'(busy_o), 32'd0);
        areset = 1'b0;
      end
    end

    // Invalid channel on a 3-channel instance, with clear held high to show set beats clear
    @(negedge aclk);
    chk("inv_rdy_idle", 32'(desc_rdy2), 32'd1);
    desc_chn_i = 2'd3;
    desc_vld2  = 1'b1;
    @(negedge aclk);
    desc_vld2 = 1'b0;
    err_clr_i = 1'b1;
    chk("inv_t1_done", 32'(done2), 32'd0);
    chk("inv_t1_busy", 32'(busy2), 32'd1);
    chk("inv_t1_rdy", 32'(desc_rdy2), 32'd0);
    chk("inv_t1_awvalid", 32'(ifc2.m_awvalid_o), 32'd0);
    chk("inv_t1_wvalid", 32'(ifc2.m_wvalid_o), 32'd0);
    @(negedge aclk);
    chk("inv_t2_done", 32'(done2), 32'd1);
    chk("inv_t2_err_set_wins", 32'(err2), 32'd1);
    chk("inv_t2_busy", 32'(busy2), 32'd0);
    chk("inv_t2_awvalid", 32'(ifc2.m_awvalid_o), 32'd0);
    @(negedge aclk);
    chk("inv_t3_done", 32'(done2), 32'd0);
    chk("inv_t3_rdy", 32'(desc_rdy2), 32'd1);
    chk("inv_t3_err_cleared", 32'(err2), 32'd0);
    err_clr_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
